// File: rtl/writeback_regfile_pkg.sv
// Shared constants for the writeback / register-file slice.
//  XLEN      : register and result bus width
//  NREGS     : number of architectural integer registers (x0 hardwired to zero)
//  CNT_W     : retired-instruction counter width
//  REG_IDX_W : register index width
//  REG_ZERO  : index of the hardwired-zero register
package writeback_regfile_pkg;

   localparam int XLEN      = 32;
   localparam int NREGS     = 32;
   localparam int CNT_W     = 64;
   localparam int REG_IDX_W = 5;

   localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/writeback_regfile_regfile_2r1w.sv
// Integer register file: NREGS x XLEN, two asynchronous read ports and one
// synchronous write port. Index 0 is never written and always reads zero.
// Ports:
//  clk      : clock, state updates on rising edge
//  rst      : synchronous active-high reset, clears every entry
//  wr_en    : write strobe
//  wr_idx   : write index
//  wr_data  : write data
//  rd_idx_a : read port A index    rd_data_a : read port A data (combinational)
//  rd_idx_b : read port B index    rd_data_b : read port B data (combinational)
module regfile_2r1w
   import writeback_regfile_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [REG_IDX_W-1:0] wr_idx,
   input  logic [XLEN-1:0]      wr_data,
   input  logic [REG_IDX_W-1:0] rd_idx_a,
   output logic [XLEN-1:0]      rd_data_a,
   input  logic [REG_IDX_W-1:0] rd_idx_b,
   output logic [XLEN-1:0]      rd_data_b
);

   logic [XLEN-1:0] regs_r [NREGS];

   // Register storage: reset clears all entries, x0 is never written.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= {XLEN{1'b0}};
         end
      end else if (wr_en && (wr_idx != REG_ZERO)) begin
         regs_r[wr_idx] <= wr_data;
      end else begin
         regs_r[wr_idx] <= regs_r[wr_idx];
      end
   end

   // Read ports: x0 forced to zero regardless of stored contents.
   always_comb begin
      rd_data_a = {XLEN{1'b0}};
      rd_data_b = {XLEN{1'b0}};
      if (rd_idx_a == REG_ZERO) begin
         rd_data_a = {XLEN{1'b0}};
      end else begin
         rd_data_a = regs_r[rd_idx_a];
      end
      if (rd_idx_b == REG_ZERO) begin
         rd_data_b = {XLEN{1'b0}};
      end else begin
         rd_data_b = regs_r[rd_idx_b];
      end
   end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: latches the execute result into a WB pipeline register,
// commits it to the register file on the following edge, serves two
// source-operand reads with bypass of the pending WB write, and counts
// retired instructions.
// Ports:
//  i_CLK, i_RST            : clock and synchronous active-high reset
//  i_EN, i_FLUSH           : stage advance and squash of the current result
//  i_RD, i_RD_PTR, i_REG_WE: execute result, destination index, write enable
//  i_RS1_PTR, i_RS2_PTR    : source operand indices
//  o_RS1, o_RS2            : source operand data (combinational)
//  o_WB_VALID/PTR/DATA     : pending WB write
//  o_INSTRET               : retired-instruction count
module writeback_regfile
   import writeback_regfile_pkg::*;
(
   input  logic                 i_CLK,
   input  logic                 i_RST,
   input  logic                 i_EN,
   input  logic                 i_FLUSH,
   input  logic [XLEN-1:0]      i_RD,
   input  logic [REG_IDX_W-1:0] i_RD_PTR,
   input  logic                 i_REG_WE,
   input  logic [REG_IDX_W-1:0] i_RS1_PTR,
   input  logic [REG_IDX_W-1:0] i_RS2_PTR,
   output logic [XLEN-1:0]      o_RS1,
   output logic [XLEN-1:0]      o_RS2,
   output logic                 o_WB_VALID,
   output logic [REG_IDX_W-1:0] o_WB_PTR,
   output logic [XLEN-1:0]      o_WB_DATA,
   output logic [CNT_W-1:0]     o_INSTRET
);

   logic                 wb_valid_r;
   logic [REG_IDX_W-1:0] wb_ptr_r;
   logic [XLEN-1:0]      wb_data_r;
   logic [CNT_W-1:0]     instret_r;
   logic [XLEN-1:0]      rf_rs1_s;
   logic [XLEN-1:0]      rf_rs2_s;

   // The RF commits whatever the WB register held before this edge, so a
   // capture and a commit on the same edge do not interfere.
   regfile_2r1w u_rf (
      .clk       (i_CLK),
      .rst       (i_RST),
      .wr_en     (wb_valid_r),
      .wr_idx    (wb_ptr_r),
      .wr_data   (wb_data_r),
      .rd_idx_a  (i_RS1_PTR),
      .rd_data_a (rf_rs1_s),
      .rd_idx_b  (i_RS2_PTR),
      .rd_data_b (rf_rs2_s)
   );

   // WB pipeline register and retired-instruction counter.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         wb_valid_r <= 1'b0;
         wb_ptr_r   <= REG_ZERO;
         wb_data_r  <= {XLEN{1'b0}};
         instret_r  <= {CNT_W{1'b0}};
      end else if (i_FLUSH) begin
         // Squashed instruction: nothing captured, nothing retired.
         wb_valid_r <= 1'b0;
      end else if (i_EN) begin
         wb_valid_r <= i_REG_WE && (i_RD_PTR != REG_ZERO);
         wb_ptr_r   <= i_RD_PTR;
         wb_data_r  <= i_RD;
         instret_r  <= instret_r + 64'd1;
      end else begin
         wb_valid_r <= 1'b0;
      end
   end

   // Operand read: x0 is zero, the pending WB write overrides stale RF data.
   always_comb begin
      o_RS1 = {XLEN{1'b0}};
      o_RS2 = {XLEN{1'b0}};
      if (i_RS1_PTR == REG_ZERO) begin
         o_RS1 = {XLEN{1'b0}};
      end else if (wb_valid_r && (wb_ptr_r == i_RS1_PTR)) begin
         o_RS1 = wb_data_r;
      end else begin
         o_RS1 = rf_rs1_s;
      end
      if (i_RS2_PTR == REG_ZERO) begin
         o_RS2 = {XLEN{1'b0}};
      end else if (wb_valid_r && (wb_ptr_r == i_RS2_PTR)) begin
         o_RS2 = wb_data_r;
      end else begin
         o_RS2 = rf_rs2_s;
      end
   end

   assign o_WB_VALID = wb_valid_r;
   assign o_WB_PTR   = wb_ptr_r;
   assign o_WB_DATA  = wb_data_r;
   assign o_INSTRET  = instret_r;

endmodule
